led_blink_decoder: RTL

//  Receive-side counterpart of the LED counter/divider: observes a blinking LED line and recovers the divide select that produced it.

---
 rtl/led_blink_decoder_if.sv | 23 ++
 rtl/led_blink_decoder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/led_blink_decoder_if.sv
// Signal bundle between the observed LED line and the blink decoder.
// The master side drives the LED line and watches the results; the slave side is the decoder.
interface led_blink_decoder_if;
  logic       led_i;
  logic [4:0] div_o;
  logic       meas_vld_o;
  logic       locked_o;
  logic       err_o;
  logic       stall_o;
  logic [1:0] state_dbg;

  // Strobes meas_vld_o/err_o are single-cycle and carry no backpressure: the consumer
  // must sample every cycle. div_o/locked_o/stall_o are levels held between updates.
  modport master (
    output led_i,
    input  div_o, meas_vld_o, locked_o, err_o, stall_o, state_dbg
  );

  modport slave (
    input  led_i,
    output div_o, meas_vld_o, locked_o, err_o, stall_o, state_dbg
  );
endinterface

// File: rtl/led_blink_decoder.sv
// Recovers the divide select of a blinking LED by timing the half-period between edges
// and requiring it to be an exact power of two: div = log2(half-period) - DIV_OFFSET.
module led_blink_decoder #(
  parameter int CNT_W      = 32,
  parameter int DIV_OFFSET = 20,
  parameter int LOCK_CNT   = 3
) (
  input  logic clk100,
  input  logic rst,
  led_blink_decoder_if.slave bus
);
  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] P_MAX  = '1;
  localparam logic [CNT_W-1:0] P_ONE  = CNT_W'(1);
  localparam logic [MC_W-1:0]  MC_ONE = MC_W'(1);
  localparam logic [MC_W-1:0]  MC_MAX = MC_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_EVAL    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              sync1, sync2, sync3;
  logic              edge_det;
  logic [CNT_W-1:0]  p_cnt, p_lat;
  logic              p_sat;
  logic [MC_W-1:0]   match_cnt, match_nxt;
  logic [4:0]        div_q, div_new;
  logic              meas_vld_q, locked_q, err_q, stall_q;
  logic              p_onehot, meas_ok;
  int                k_idx;

  // Two sync stages, then a third copy only for edge comparison.
  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.led_i;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_det = sync2 ^ sync3;
  assign p_sat    = (p_cnt == P_MAX);

  // p_lat captures the count at the edge, i.e. exact cycles since the previous edge.
  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      p_cnt <= '0;
      p_lat <= '0;
    end else if (edge_det) begin
      p_cnt <= P_ONE;
      p_lat <= p_cnt;
    end else if (!p_sat) begin
      p_cnt <= p_cnt + P_ONE;
    end
  end

  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (edge_det) state_nxt = S_MEASURE;
      S_MEASURE: begin
        if (edge_det)   state_nxt = S_EVAL;
        else if (p_sat) state_nxt = S_IDLE;
      end
      S_EVAL:    state_nxt = edge_det ? S_EVAL : S_MEASURE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Measurement decode and lock bookkeeping for the EVAL cycle.
  always_comb begin
    k_idx = 0;
    for (int i = 0; i < CNT_W; i++) begin
      if (p_lat[i]) k_idx = i;
    end
    p_onehot = (p_lat != '0) && ((p_lat & (p_lat - P_ONE)) == '0);
    meas_ok  = p_onehot && (k_idx >= DIV_OFFSET) && ((k_idx - DIV_OFFSET) <= 31);
    div_new  = 5'(k_idx - DIV_OFFSET);
    if ((match_cnt == '0) || (div_new != div_q)) match_nxt = MC_ONE;
    else if (match_cnt == MC_MAX)                match_nxt = match_cnt;
    else                                         match_nxt = match_cnt + MC_ONE;
  end

  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      meas_vld_q <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
      match_cnt  <= '0;
    end else begin
      meas_vld_q <= 1'b0;
      err_q      <= 1'b0;
      if (state == S_IDLE && edge_det) begin
        stall_q <= 1'b0;
      end else if (state == S_MEASURE && !edge_det && p_sat) begin
        stall_q   <= 1'b1;
        locked_q  <= 1'b0;
        match_cnt <= '0;
      end else if (state == S_EVAL) begin
        if (meas_ok) begin
          div_q      <= div_new;
          meas_vld_q <= 1'b1;
          match_cnt  <= match_nxt;
          locked_q   <= (match_nxt == MC_MAX);
        end else begin
          err_q     <= 1'b1;
          locked_q  <= 1'b0;
          match_cnt <= '0;
        end
      end
    end
  end

  assign bus.div_o      = div_q;
  assign bus.meas_vld_o = meas_vld_q;
  assign bus.locked_o   = locked_q;
  assign bus.err_o      = err_q;
  assign bus.stall_o    = stall_q;
  assign bus.state_dbg  = state;
endmodule
